// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller.
// Derives a registered divided clock div_clk and a period-end strobe div_tick
// from clk. The ratio N is loaded through a valid/ready port and only takes
// effect on a period boundary, so div_clk never produces a short pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active low
//   enable     run request (level)
//   cfg_valid  new ratio offered
//   cfg_div    offered ratio N (must be >= 2)
//   cfg_ready  controller accepts a ratio this cycle
//   div_clk    divided clock: high for the first floor(N/2) cycles of a period
//   div_tick   high in the last clk cycle of each period
//   div_ratio  ratio currently in effect
//   busy       controller is not idle
//   err        one-cycle pulse after an invalid ratio is dropped
module clk_div_ctrl #(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             div_clk,
   output logic             div_tick,
   output logic [CNT_W-1:0] div_ratio,
   output logic             busy,
   output logic             err
);

   // Reject an unusable reset ratio at elaboration.
   if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
      $error("clk_div_ctrl: DEFAULT_DIV out of range");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [CNT_W-1:0] ratio_n;
   logic [CNT_W-1:0] pend_div, pend_div_n;
   logic             pend_vld, pend_vld_n;
   logic             div_clk_n, div_tick_n, err_n;
   logic             last, xfer, bad;

   assign last = (cnt == div_ratio - CNT_W'(1));
   assign xfer = cfg_valid & cfg_ready;
   assign bad  = (cfg_div < CNT_W'(2));
   assign busy = (state != IDLE);

   // Next-state, ratio bookkeeping and next registered outputs.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      ratio_n    = div_ratio;
      pend_div_n = pend_div;
      pend_vld_n = pend_vld;
      err_n      = 1'b0;

      case (state)
         IDLE: begin
            // A ratio captured on the final edge of a stop is still pending here.
            if (pend_vld) begin
               ratio_n    = pend_div;
               pend_vld_n = 1'b0;
            end
            if (xfer && !bad) begin
               ratio_n = cfg_div;
            end
            if (enable) begin
               state_n = RUN;
            end
            cnt_n = '0;
         end
         RUN, STOPPING: begin
            if (last) begin
               cnt_n = '0;
               // Only a ratio registered before this tick cycle is applied here.
               if (pend_vld) begin
                  ratio_n    = pend_div;
                  pend_vld_n = 1'b0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end

            if (!enable) begin
               if (state == STOPPING && last) begin
                  state_n = IDLE;
               end else begin
                  state_n = STOPPING;
               end
            end else begin
               state_n = RUN;
            end

            if (xfer && !bad) begin
               pend_div_n = cfg_div;
               pend_vld_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      if (xfer && bad) begin
         err_n = 1'b1;
      end

      if (state_n == IDLE) begin
         div_clk_n  = 1'b0;
         div_tick_n = 1'b0;
      end else begin
         div_clk_n  = (cnt_n < (ratio_n >> 1));
         div_tick_n = (cnt_n == ratio_n - CNT_W'(1));
      end
   end

   // All state and outputs registered; reset aborts any period in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_ratio <= CNT_W'(DEFAULT_DIV);
         pend_div  <= '0;
         pend_vld  <= 1'b0;
         cfg_ready <= 1'b1;
         div_clk   <= 1'b0;
         div_tick  <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         div_ratio <= ratio_n;
         pend_div  <= pend_div_n;
         pend_vld  <= pend_vld_n;
         cfg_ready <= ~pend_vld_n;
         div_clk   <= div_clk_n;
         div_tick  <= div_tick_n;
         err       <= err_n;
      end
   end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller: derives a divided clock `div_clk` and a period-end strobe `div_tick` from `clk`.
- Divide ratio N is runtime-configurable through a valid/ready config port.
- Ratio changes are applied only at period boundaries, so `div_clk` never glitches.
- Replaces the fixed divide-by-2/divide-by-3 instances; sits between the system config bus and the derived-clock consumers.

Parameters:
- CNT_W, 8: counter and ratio width; max N = 2^CNT_W-1.
- DEFAULT_DIV, 3: ratio after reset. Must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1; an elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; asserted when rst==0.
- enable  in  1  run request, level-sensitive.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  CNT_W  offered ratio N.
- cfg_ready  out  1  controller can accept a ratio this cycle.
- div_clk  out  1  divided clock, registered.
- div_tick  out  1  high in the last clk cycle of each div period.
- div_ratio  out  CNT_W  ratio currently in effect.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse: invalid ratio rejected.

Behaviour:
- Reset (rst==0, async):
  - state=IDLE, cnt=0, div_ratio=DEFAULT_DIV, pending cleared.
  - div_clk=0, div_tick=0, cfg_ready=1, err=0, busy=0.
  - Reset mid-period aborts immediately; no period completion.
- Outputs are registered. cnt is the phase counter, range 0..N-1. H = N>>1 (floor).
- Output timing within a period:
  - In a cycle where cnt==k (RUN/STOPPING): div_clk = (k < H), div_tick = (k == N-1).
  - N=2: 1,0. N=3: 1,0,0. N=4: 1,1,0,0. N=5: 1,1,0,0,0.
- States:
  - IDLE: cnt=0, div_clk=0, div_tick=0. On the clock edge where enable==1, go to RUN. The first RUN cycle has cnt=0, div_clk=1, i.e. 1 cycle latency from enable.
  - RUN: cnt increments and wraps N-1 -> 0. If enable==0 is sampled, go to STOPPING; the counter continues.
  - STOPPING: same counting as RUN.
    - If enable==1 is sampled again, return to RUN with no phase disturbance.
    - On the edge ending the cnt==N-1 cycle with enable==0, go to IDLE. div_clk=0 thereafter.
    - Periods are never truncated.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready on a clock edge.
  - Invalid ratio (cfg_div < 2):
    - Transfer completes (dropped), err=1 in the next cycle for exactly 1 cycle.
    - div_ratio and pending are unchanged; cfg_ready stays 1.
  - Valid ratio in IDLE: div_ratio=cfg_div in the next cycle; cfg_ready stays 1.
  - Valid ratio in RUN/STOPPING:
    - Stored as pending; cfg_ready=0 from the next cycle.
    - Applied at the first tick edge (end of a cnt==N-1 cycle) where pending was already registered before that cycle.
    - If captured during a tick cycle, it waits one more full period.
    - On application: div_ratio updates, cnt restarts at 0 under the new N, pending clears, and cfg_ready returns to 1 in the same cycle.
  - Pending in STOPPING that reaches IDLE: applied at that same final edge; div_ratio shows the new N in IDLE.
- Simultaneous events:
  - enable falling together with a pending apply: the apply happens, the stop proceeds under the new N.
  - cfg_valid held with cfg_ready=0: not accepted; the source must hold its data.
- No counter overflow: cnt compares against div_ratio-1 and never exceeds it.
- busy: combinational from state.
- err: registered.

Test Plan:
- Reset with DEFAULT_DIV=3; release rst; raise enable -> after 1 cycle, div_clk repeats 1,0,0; div_tick high every 3rd cycle on the second 0; busy=1.
- In IDLE, write cfg_div=4, then enable -> div_ratio=4 the next cycle; div_clk 1,1,0,0 repeating; cfg_ready never drops.
- Running at N=3, write cfg_div=5 mid-period -> cfg_ready=0 until the current period's tick; next period is 1,1,0,0,0; div_ratio changes exactly at that boundary; no short div_clk pulse.
- Write cfg_div=0, then cfg_div=1 -> err pulses 1 cycle each; div_ratio unchanged; waveform unaffected.
- Running at N=4, drop enable at cnt==1 -> remaining cycles 0,0 with tick, then IDLE, busy=0. Re-raise enable at cnt==2 in a second run -> no interruption.
- Assert rst low at cnt==1 of N=5 while pending=7 -> all outputs go to reset values immediately; div_ratio=3; pending discarded.
